// File: rtl/timer_tick_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | timer_tick_scheduler: acknowledges interval-timer timeouts and turns each  |
// | one into a tick that advances NUM_CH software countdown channels.          |
// | Optional feature macro: TICK_PRESCALE_EN (8-bit channel prescaler, addr 7).|
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module timer_tick_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic              tmr_irq,
  input  logic [2:0]        s_address,
  input  logic              s_chipselect,
  input  logic              s_write_n,
  input  logic [15:0]       s_writedata,
  output logic [15:0]       s_readdata,
  output logic [NUM_CH-1:0] ch_expire,
  output logic              irq
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_ACK    = 3'd2,
    S_HOLD   = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  state_t                  r_state, w_state_next;
  logic                    r_tmr_cs, w_tmr_cs;
  logic [2:0]              r_tmr_addr, w_tmr_addr;
  logic [15:0]             r_tmr_data, w_tmr_data;
  logic [15:0]             r_tick_count;
  logic [15:0]             r_readdata, w_rdata;
  logic [NUM_CH-1:0]       r_enable, r_pending;
  logic [NUM_CH-1:0]       w_en_next, w_en_rise, w_en_wdata, w_w1c, w_expire;
  logic [NUM_CH*CNT_W-1:0] w_reload_all;
  logic                    w_cfg_wr, w_wr_en, w_wr_pend, w_update, w_advance;

  // Timer bus outputs are registered so the write appears in the cycle after the decision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_INIT;
      r_tmr_cs   <= 1'b0;
      r_tmr_addr <= 3'd0;
      r_tmr_data <= 16'h0000;
    end else begin
      r_state    <= w_state_next;
      r_tmr_cs   <= w_tmr_cs;
      r_tmr_addr <= w_tmr_addr;
      r_tmr_data <= w_tmr_data;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tmr_cs     = 1'b0;
    w_tmr_addr   = 3'd0;
    w_tmr_data   = 16'h0000;
    case (r_state)
      S_INIT: begin
        w_state_next = S_IDLE;
        w_tmr_cs     = 1'b1;
        w_tmr_addr   = 3'd1;
        w_tmr_data   = 16'h0001;
      end
      S_IDLE: begin
        if (tmr_irq) begin
          w_state_next = S_ACK;
          w_tmr_cs     = 1'b1;
        end
      end
      S_ACK:    w_state_next = S_HOLD;
      S_HOLD:   w_state_next = S_UPDATE;
      S_UPDATE: w_state_next = S_IDLE;
      default:  w_state_next = S_INIT;
    endcase
  end

  assign tmr_chipselect = r_tmr_cs;
  assign tmr_write_n    = ~r_tmr_cs;
  assign tmr_address    = r_tmr_addr;
  assign tmr_writedata  = r_tmr_data;

  assign w_cfg_wr   = s_chipselect & ~s_write_n;
  assign w_wr_en    = w_cfg_wr & (s_address == 3'd4);
  assign w_wr_pend  = w_cfg_wr & (s_address == 3'd5);
  assign w_update   = (r_state == S_UPDATE);
  assign w_en_wdata = s_writedata[NUM_CH-1:0];
  assign w_en_next  = w_wr_en ? w_en_wdata : r_enable;
  assign w_en_rise  = w_wr_en ? (w_en_wdata & ~r_enable) : '0;
  assign w_w1c      = w_wr_pend ? w_en_wdata : '0;

`ifdef TICK_PRESCALE_EN
  logic [7:0] r_prescale, r_pre_cnt;
  logic       w_wr_pre;

  assign w_wr_pre  = w_cfg_wr & (s_address == 3'd7);
  assign w_advance = w_update & (r_pre_cnt == r_prescale);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= 8'd0;
      r_pre_cnt  <= 8'd0;
    end else if (w_wr_pre) begin
      r_prescale <= s_writedata[7:0];
      r_pre_cnt  <= 8'd0;
    end else if (w_update) begin
      r_pre_cnt  <= w_advance ? 8'd0 : r_pre_cnt + 8'd1;
    end
  end
`else
  assign w_advance = w_update;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] r_count, r_reload;
    logic             w_load, w_step;

    // Only addresses 0..3 map to channels; 4..7 are the shared registers.
    assign w_load      = w_cfg_wr & ~s_address[2] & (s_address == 3'(c));
    assign w_step      = w_advance & r_enable[c] & w_en_next[c];
    assign w_expire[c] = w_step & (r_count == '0) & ~w_load;
    assign w_reload_all[c*CNT_W +: CNT_W] = r_reload;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_count  <= '0;
        r_reload <= '0;
      end else if (w_load) begin
        r_reload <= s_writedata[CNT_W-1:0];
        r_count  <= s_writedata[CNT_W-1:0];
      end else if (w_en_rise[c]) begin
        r_count  <= r_reload;
      end else if (w_step) begin
        r_count  <= (r_count == '0) ? r_reload : r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable     <= '0;
      r_pending    <= '0;
      r_tick_count <= 16'h0000;
      r_readdata   <= 16'h0000;
    end else begin
      r_enable   <= w_en_next;
      r_pending  <= (r_pending & ~w_w1c) | w_expire;
      r_readdata <= w_rdata;
      if (w_update)
        r_tick_count <= r_tick_count + 16'd1;
    end
  end

  always_comb begin
    w_rdata = 16'h0000;
    case (s_address)
      3'd4: w_rdata[NUM_CH-1:0] = r_enable;
      3'd5: w_rdata[NUM_CH-1:0] = r_pending;
      3'd6: w_rdata = r_tick_count;
      3'd7: begin
`ifdef TICK_PRESCALE_EN
        w_rdata[7:0] = r_prescale;
`endif
      end
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          if (s_address == 3'(i))
            w_rdata = 16'(w_reload_all[i*CNT_W +: CNT_W]);
      end
    endcase
  end

  assign s_readdata = r_readdata;
  assign ch_expire  = w_expire;
  assign irq        = |(r_pending & r_enable);

endmodule
`default_nettype wire

// File: tb/tb_timer_tick_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_timer_tick_scheduler: directed self-checking bench for                  |
// | timer_tick_scheduler (prescale checks follow TICK_PRESCALE_EN).            |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_timer_tick_scheduler;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        tmr_address;
  logic              tmr_chipselect;
  logic              tmr_write_n;
  logic [15:0]       tmr_writedata;
  logic              tmr_irq = 1'b0;
  logic [2:0]        s_address = 3'd0;
  logic              s_chipselect = 1'b0;
  logic              s_write_n = 1'b1;
  logic [15:0]       s_writedata = 16'h0000;
  logic [15:0]       s_readdata;
  logic [NUM_CH-1:0] ch_expire;
  logic              irq;

  int n_vec = 0;
  int n_fail = 0;
  int exp_ticks = 0;

  timer_tick_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .ch_expire(ch_expire), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    s_chipselect = 1'b1; s_write_n = 1'b0; s_address = a; s_writedata = d;
    @(negedge clk);
    s_chipselect = 1'b0; s_write_n = 1'b1;
  endtask

  task automatic cfg_read(input logic [2:0] a, output logic [15:0] d);
    s_chipselect = 1'b1; s_write_n = 1'b1; s_address = a;
    @(negedge clk);
    d = s_readdata;
    s_chipselect = 1'b0;
  endtask

  // One timer timeout; optional config write lands in the UPDATE cycle.
  task automatic tick(input bit wr, input logic [2:0] a, input logic [15:0] d,
                      output logic [NUM_CH-1:0] seen);
    tmr_irq = 1'b1;
    @(negedge clk);
    check("ack_cs", 32'(tmr_chipselect), 1);
    check("ack_wn", 32'(tmr_write_n), 0);
    check("ack_addr", 32'(tmr_address), 0);
    check("ack_data", 32'(tmr_writedata), 0);
    tmr_irq = 1'b0;
    @(negedge clk);
    check("hold_cs", 32'(tmr_chipselect), 0);
    @(negedge clk);
    if (wr) begin
      s_chipselect = 1'b1; s_write_n = 1'b0; s_address = a; s_writedata = d;
    end
    #1 seen = ch_expire;
    @(negedge clk);
    s_chipselect = 1'b0; s_write_n = 1'b1;
    exp_ticks++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_CH-1:0] e;
    logic [15:0]       rd;
    logic [15:0]       exp_p;

    repeat (3) @(negedge clk);
    check("rst_cs", 32'(tmr_chipselect), 0);
    check("rst_wn", 32'(tmr_write_n), 1);
    check("rst_taddr", 32'(tmr_address), 0);
    check("rst_tdata", 32'(tmr_writedata), 0);
    check("rst_exp", 32'(ch_expire), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_rdata", 32'(s_readdata), 0);
    reset_n = 1'b1;

    @(negedge clk);
    check("init_cs", 32'(tmr_chipselect), 1);
    check("init_wn", 32'(tmr_write_n), 0);
    check("init_addr", 32'(tmr_address), 1);
    check("init_data", 32'(tmr_writedata), 16'h0001);
    @(negedge clk);
    check("idle_cs", 32'(tmr_chipselect), 0);
    cfg_read(3'd6, rd); check("tick0", 32'(rd), 0);
    cfg_read(3'd4, rd); check("en0", 32'(rd), 0);

    // Single tick, then no repeated acknowledge.
    tick(1'b0, 3'd0, 16'h0, e);
    check("t1_exp", 32'(e), 0);
    @(negedge clk); check("no_ack2_a", 32'(tmr_chipselect), 0);
    @(negedge clk); check("no_ack2_b", 32'(tmr_chipselect), 0);
    cfg_read(3'd6, rd); check("tick1", 32'(rd), 1);

    // reload 2 gives expiry every third tick.
    cfg_write(3'd0, 16'd2);
    cfg_write(3'd4, 16'h0001);
    cfg_read(3'd0, rd); check("rld0", 32'(rd), 2);
    for (int k = 1; k <= 9; k++) begin
      tick(1'b0, 3'd0, 16'h0, e);
      check($sformatf("p3_t%0d", k), 32'(e), (k % 3 == 0) ? 1 : 0);
      if (k == 3) begin
        check("irq_t3", 32'(irq), 1);
        cfg_read(3'd5, rd); check("pend_t3", 32'(rd), 1);
      end
    end
    check("irq_pre_w1c", 32'(irq), 1);
    cfg_write(3'd5, 16'h0001);
    check("irq_post_w1c", 32'(irq), 0);
    cfg_read(3'd5, rd); check("pend_clr", 32'(rd), 0);
    cfg_read(3'd6, rd); check("tick10", 32'(rd), exp_ticks);

    // CPU reload write in the UPDATE cycle beats the channel step.
    cfg_write(3'd1, 16'd3);
    cfg_write(3'd4, 16'h0003);
    tick(1'b1, 3'd1, 16'd5, e);
    check("ldwin_exp", 32'(e), 0);
    cfg_read(3'd1, rd); check("rld1", 32'(rd), 5);
    for (int k = 1; k <= 6; k++) begin
      tick(1'b0, 3'd0, 16'h0, e);
      check($sformatf("ld_t%0d", k), 32'(e),
            {30'd0, (k == 6), (k == 2 || k == 5)});
    end

    // W1C coinciding with an expiry: the set wins.
    cfg_write(3'd5, 16'h0003);
    tick(1'b0, 3'd0, 16'h0, e);
    check("w1c_pre", 32'(e), 0);
    tick(1'b1, 3'd5, 16'h0001, e);
    check("w1c_exp", 32'(e), 1);
    cfg_read(3'd5, rd); check("w1c_pend", 32'(rd), 1);
    check("w1c_irq", 32'(irq), 1);

    // reload 0 expires every tick; disable in UPDATE suppresses the step.
    cfg_write(3'd0, 16'd0);
    tick(1'b0, 3'd0, 16'h0, e);
    check("r0_exp", 32'(e), 1);
    tick(1'b1, 3'd4, 16'h0002, e);
    check("dis_upd", 32'(e), 0);
    cfg_read(3'd4, rd); check("en2", 32'(rd), 2);
    tick(1'b0, 3'd0, 16'h0, e);
    check("dis_hold", 32'(e), 0);

    // Read-only writes ignored; unused reloads read 0.
    cfg_write(3'd6, 16'h1234);
    cfg_read(3'd6, rd); check("tick_ro", 32'(rd), exp_ticks);
    cfg_read(3'd2, rd); check("rld2", 32'(rd), 0);
    cfg_read(3'd3, rd); check("rld3", 32'(rd), 0);

    // Prescale register (reads 0 and has no effect when the feature is absent).
    cfg_write(3'd4, 16'h0001);
    cfg_write(3'd7, 16'h0001);
`ifdef TICK_PRESCALE_EN
    exp_p = 16'h0001;
`else
    exp_p = 16'h0000;
`endif
    cfg_read(3'd7, rd); check("presc_rd", 32'(rd), 32'(exp_p));
    for (int k = 1; k <= 4; k++) begin
      tick(1'b0, 3'd0, 16'h0, e);
      check($sformatf("ps_t%0d", k), 32'(e),
            (exp_p == 16'h0001) ? ((k % 2 == 0) ? 1 : 0) : 1);
    end
    cfg_read(3'd6, rd); check("tick_end", 32'(rd), exp_ticks);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
